sqed_consistency_monitor: RTL and testbench

//  Parametrised SQED checker for the DutTop formal harness. Generates the warm-up enable that switches

---
 rtl/sqed_pkg.sv | 13 +
 rtl/sqed_commit_popcount.sv | 29 ++
 rtl/sqed_consistency_monitor.sv | 113 +++++++++++
 tb/tb_sqed_consistency_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sqed_pkg.sv
// sqed_pkg: shared types and helpers for the SQED consistency monitor.
// Contents: checker state enum, legacy single-pair register index,
// and lane classifiers for the original and duplicate register regions.
package sqed_pkg;
  typedef enum logic [1:0] {WARMUP, RUN, SAT} state_t;
  localparam int LEGACY_REG = 7;
  function automatic logic lane_is_orig(input int d, input int npair);
    return d >= 1 && d <= npair;
  endfunction
  function automatic logic lane_is_dup(input int d, input int npair);
    return d > npair && d <= 2 * npair;
  endfunction
endpackage

// File: rtl/sqed_commit_popcount.sv
// sqed_commit_popcount: per-cycle count of original and duplicate writebacks.
// Ports:
//   valid, rfwen  per-lane commit valid / int RF write enable
//   wdest         per-lane destination, 8 bits per lane, low RW bits used
//   orig_cnt      lanes writing regs 1..NPAIR this cycle
//   dup_cnt       lanes writing regs NPAIR+1..2*NPAIR this cycle
module sqed_commit_popcount import sqed_pkg::*; #(
  parameter int COMMIT_W = 8,
  parameter int NPAIR = 12,
  parameter int RW = 5,
  parameter int PW = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0]   valid,
  input  logic [COMMIT_W-1:0]   rfwen,
  input  logic [COMMIT_W*8-1:0] wdest,
  output logic [PW-1:0]         orig_cnt,
  output logic [PW-1:0]         dup_cnt
);
  logic unused;
  assign unused = ^wdest;
  always_comb begin
    orig_cnt = '0;
    dup_cnt = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      orig_cnt = orig_cnt + PW'(valid[i] && rfwen[i] && lane_is_orig(int'(wdest[i*8 +: RW]), NPAIR));
      dup_cnt = dup_cnt + PW'(valid[i] && rfwen[i] && lane_is_dup(int'(wdest[i*8 +: RW]), NPAIR));
    end
  end
endmodule

// File: rtl/sqed_consistency_monitor.sv
// sqed_consistency_monitor: SQED warm-up enable, writeback counting and
// original/duplicate register consistency check.
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   commit_*       difftest commit ports (valid, rfwen, 8-bit wdest per lane)
//   arf_state      architectural int regs, reg i at [i*XLEN +: XLEN]
//   qed_ena        warm-up done, fetch from the QED FIFO
//   qed_ready      counts equal and above MIN_COMMITS, check this cycle
//   mismatch       a checked pair differs while qed_ready
//   fail/fail_idx  sticky failure and lowest failing original reg
//   num_orig/dup   saturating writeback counters
//   cnt_sat        a counter saturated, checking disabled
// Build option: SQED_CHECK_ALL_EN checks every pair 1..NPAIR; otherwise only
// the legacy pair LEGACY_REG vs LEGACY_REG+NPAIR is checked.
module sqed_consistency_monitor import sqed_pkg::*; #(
  parameter int COMMIT_W = 8,
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NPAIR = 12,
  parameter int CNT_W = 16,
  parameter int WARMUP_CYC = 63,
  parameter int MIN_COMMITS = 12,
  localparam int RW = $clog2(NREG)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COMMIT_W-1:0]    commit_valid,
  input  logic [COMMIT_W-1:0]    commit_rfwen,
  input  logic [COMMIT_W*8-1:0]  commit_wdest,
  input  logic [NREG*XLEN-1:0]   arf_state,
  output logic                   qed_ena,
  output logic                   qed_ready,
  output logic                   mismatch,
  output logic                   fail,
  output logic [RW-1:0]          fail_idx,
  output logic [CNT_W-1:0]       num_orig,
  output logic [CNT_W-1:0]       num_dup,
  output logic                   cnt_sat
);
  localparam int PW = $clog2(COMMIT_W + 1);
  state_t state;
  logic [7:0] warm;
  logic [NREG*XLEN-1:0] arf_q;
  logic [PW-1:0] orig_pc, dup_pc;
  logic [CNT_W:0] orig_sum, dup_sum;
  logic [CNT_W-1:0] orig_nx, dup_nx;
  logic hit;
  logic [RW-1:0] hit_idx;
  logic unused;
  sqed_commit_popcount #(.COMMIT_W(COMMIT_W), .NPAIR(NPAIR), .RW(RW)) u_pop (
    .valid(commit_valid),
    .rfwen(commit_rfwen),
    .wdest(commit_wdest),
    .orig_cnt(orig_pc),
    .dup_cnt(dup_pc)
  );
  // Extra carry bit detects overflow so the counters clamp at all-ones.
  assign orig_sum = {1'b0, num_orig} + (CNT_W+1)'(orig_pc);
  assign dup_sum = {1'b0, num_dup} + (CNT_W+1)'(dup_pc);
  assign orig_nx = orig_sum[CNT_W] ? '1 : orig_sum[CNT_W-1:0];
  assign dup_nx = dup_sum[CNT_W] ? '1 : dup_sum[CNT_W-1:0];
  assign unused = ^arf_q;
`ifdef SQED_CHECK_ALL_EN
  // Descending scan so the lowest differing pair wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int r = NPAIR; r >= 1; r--)
      if (arf_q[r*XLEN +: XLEN] != arf_q[(r+NPAIR)*XLEN +: XLEN]) begin
        hit = 1'b1;
        hit_idx = RW'(r);
      end
  end
`else
  assign hit = arf_q[LEGACY_REG*XLEN +: XLEN] != arf_q[(LEGACY_REG+NPAIR)*XLEN +: XLEN];
  assign hit_idx = RW'(LEGACY_REG);
`endif
  assign qed_ready = state == RUN && num_orig == num_dup && num_orig > CNT_W'(MIN_COMMITS);
  assign mismatch = qed_ready && hit;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WARMUP;
      warm <= '0;
      arf_q <= '0;
      num_orig <= '0;
      num_dup <= '0;
      qed_ena <= 1'b0;
      cnt_sat <= 1'b0;
      fail <= 1'b0;
      fail_idx <= '0;
    end else begin
      arf_q <= arf_state;
      if (state != SAT) begin
        num_orig <= orig_nx;
        num_dup <= dup_nx;
      end
      if (mismatch && !fail) begin
        fail <= 1'b1;
        fail_idx <= hit_idx;
      end
      if (state == WARMUP) begin
        warm <= warm + 8'd1;
        if (warm == 8'(WARMUP_CYC)) begin
          state <= RUN;
          qed_ena <= 1'b1;
        end
      end else if (state == RUN && (&orig_nx || &dup_nx)) begin
        state <= SAT;
        cnt_sat <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sqed_consistency_monitor.sv
// tb_sqed_consistency_monitor: self-checking bench for sqed_consistency_monitor.
module tb_sqed_consistency_monitor;
  localparam int XLEN = 64, NREG = 32, NPAIR = 12, WARM = 63, MINC = 12;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] valid, rfwen;
  logic [63:0] wdest;
  logic [NREG*XLEN-1:0] arf;
  logic ena [2], rdy [2], mm [2], fl [2], st [2];
  logic [4:0] fidx [2];
  logic [15:0] no0, nd0;
  logic [3:0] no1, nd1;
  int nvec = 0, nerr = 0;
  int cap [2] = '{65535, 15};
  int m_cyc [2], m_o [2], m_d [2], m_idx [2];
  bit m_sat [2], m_fail [2];
  logic [NREG*XLEN-1:0] m_arf;
  typedef struct { logic [7:0] v, w; logic [63:0] d; int eo, ed; } vec_t;
  vec_t tbl [9];

  sqed_consistency_monitor dut0 (
    .clock(clock), .reset(reset), .commit_valid(valid), .commit_rfwen(rfwen),
    .commit_wdest(wdest), .arf_state(arf), .qed_ena(ena[0]), .qed_ready(rdy[0]),
    .mismatch(mm[0]), .fail(fl[0]), .fail_idx(fidx[0]), .num_orig(no0),
    .num_dup(nd0), .cnt_sat(st[0]));
  sqed_consistency_monitor #(.CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .commit_valid(valid), .commit_rfwen(rfwen),
    .commit_wdest(wdest), .arf_state(arf), .qed_ena(ena[1]), .qed_ready(rdy[1]),
    .mismatch(mm[1]), .fail(fl[1]), .fail_idx(fidx[1]), .num_orig(no1),
    .num_dup(nd1), .cnt_sat(st[1]));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit pdiff(int r);
    return m_arf[r*XLEN +: XLEN] != m_arf[(r+NPAIR)*XLEN +: XLEN];
  endfunction

  function automatic int first_bad();
`ifdef SQED_CHECK_ALL_EN
    for (int r = 1; r <= NPAIR; r++) if (pdiff(r)) return r;
    return 0;
`else
    return pdiff(7) ? 7 : 0;
`endif
  endfunction

  function automatic bit m_ready(int i);
    return m_cyc[i] > WARM && !m_sat[i] && m_o[i] == m_d[i] && m_o[i] > MINC;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_o[i] = 0; m_d[i] = 0; m_idx[i] = 0; m_sat[i] = 0; m_fail[i] = 0;
    end
    m_arf = '0;
  endtask

  task automatic model_edge();
    int no, nd, d;
    no = 0; nd = 0;
    for (int l = 0; l < 8; l++) begin
      d = int'(wdest[l*8 +: 5]);
      if (valid[l] && rfwen[l] && d >= 1 && d <= NPAIR) no++;
      if (valid[l] && rfwen[l] && d > NPAIR && d <= 2*NPAIR) nd++;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_ready(i) && first_bad() != 0 && !m_fail[i]) begin
        m_fail[i] = 1; m_idx[i] = first_bad();
      end
      if (!m_sat[i]) begin
        bit run = m_cyc[i] > WARM;
        m_o[i] = (m_o[i] + no > cap[i]) ? cap[i] : m_o[i] + no;
        m_d[i] = (m_d[i] + nd > cap[i]) ? cap[i] : m_d[i] + nd;
        if (run && (m_o[i] == cap[i] || m_d[i] == cap[i])) m_sat[i] = 1;
      end
      m_cyc[i]++;
    end
    m_arf = arf;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_qed_ena", i), 32'(ena[i]), 32'(m_cyc[i] > WARM));
      chk($sformatf("d%0d_qed_ready", i), 32'(rdy[i]), 32'(m_ready(i)));
      chk($sformatf("d%0d_mismatch", i), 32'(mm[i]), 32'(m_ready(i) && first_bad() != 0));
      chk($sformatf("d%0d_fail", i), 32'(fl[i]), 32'(m_fail[i]));
      chk($sformatf("d%0d_fail_idx", i), 32'(fidx[i]), 32'(m_idx[i]));
      chk($sformatf("d%0d_num_orig", i), i == 0 ? 32'(no0) : 32'(no1), 32'(m_o[i]));
      chk($sformatf("d%0d_num_dup", i), i == 0 ? 32'(nd0) : 32'(nd1), 32'(m_d[i]));
      chk($sformatf("d%0d_cnt_sat", i), 32'(st[i]), 32'(m_sat[i]));
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    valid = '0; rfwen = '0; wdest = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    arf = '0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic warm_check();
    idle_inputs();
    for (int k = 1; k <= WARM + 1; k++) begin
      step();
      if (k == WARM) chk("qed_ena_cyc63", 32'(ena[0]), 0);
    end
    chk("qed_ena_cyc64", 32'(ena[0]), 1);
    chk("qed_ready_idle", 32'(rdy[0]), 0);
  endtask

  initial begin
    logic [15:0] prev_o, prev_d;
    idle_inputs();
    arf = '0;
    tbl[0] = '{8'hFF, 8'hFF, {8{8'd5}}, 8, 0};
    tbl[1] = '{8'hFF, 8'hFF, 64'h0, 0, 0};
    tbl[2] = '{8'hFF, 8'hFF, {8{8'd25}}, 0, 0};
    tbl[3] = '{8'hFF, 8'h00, {8{8'd5}}, 0, 0};
    tbl[4] = '{8'hFF, 8'hFF, {8'd7, 8'd19, 8'd31, 8'd0, 8'd1, 8'd24, 8'd13, 8'd12}, 3, 3};
    tbl[5] = '{8'h0F, 8'hFF, {8{8'd20}}, 0, 4};
    tbl[6] = '{8'hFF, 8'hFF, {8{8'd37}}, 8, 0};
    tbl[7] = '{8'hFF, 8'hAA, {8{8'd24}}, 0, 4};
    tbl[8] = '{8'h01, 8'hFF, {8{8'd12}}, 1, 0};
    // lane classification table, applied during warm-up where counting is live
    do_reset();
    for (int t = 0; t < 9; t++) begin
      prev_o = no0; prev_d = nd0;
      valid = tbl[t].v; rfwen = tbl[t].w; wdest = tbl[t].d;
      step();
      chk($sformatf("tbl%0d_orig_inc", t), 32'(no0 - prev_o), 32'(tbl[t].eo));
      chk($sformatf("tbl%0d_dup_inc", t), 32'(nd0 - prev_d), 32'(tbl[t].ed));
    end
    // warm-up timing with no commits
    do_reset();
    warm_check();
    // 13 balanced writebacks to r7/r19 with equal values
    arf[7*XLEN +: XLEN] = 64'h5;
    arf[19*XLEN +: XLEN] = 64'h5;
    valid = 8'hFF; rfwen = 8'hFF;
    wdest = {8'd19, 8'd19, 8'd19, 8'd19, 8'd7, 8'd7, 8'd7, 8'd7};
    repeat (3) step();
    valid = 8'h11;
    step();
    idle_inputs();
    step();
    chk("t2_num_orig", 32'(no0), 13);
    chk("t2_qed_ready", 32'(rdy[0]), 1);
    chk("t2_mismatch", 32'(mm[0]), 0);
    chk("t2_fail", 32'(fl[0]), 0);
    // pair 3 diverges
    arf[3*XLEN +: XLEN] = 64'h1;
    arf[15*XLEN +: XLEN] = 64'h2;
    step();
`ifdef SQED_CHECK_ALL_EN
    chk("t3_mismatch", 32'(mm[0]), 1);
    step();
    chk("t3_fail", 32'(fl[0]), 1);
    chk("t3_fail_idx", 32'(fidx[0]), 3);
`else
    chk("t3_mismatch", 32'(mm[0]), 0);
    step();
    chk("t3_fail", 32'(fl[0]), 0);
`endif
    // legacy pair diverges too; first captured index must stick
    arf[7*XLEN +: XLEN] = 64'h9;
    repeat (2) step();
    chk("t3b_fail", 32'(fl[0]), 1);
`ifdef SQED_CHECK_ALL_EN
    chk("t3b_fail_idx", 32'(fidx[0]), 3);
`else
    chk("t3b_fail_idx", 32'(fidx[0]), 7);
`endif
    // 4-bit counter saturates from 13 with an 8-wide orig commit
    valid = 8'hFF; rfwen = 8'hFF; wdest = {8{8'd5}};
    step();
    chk("t5_num_orig_sat", 32'(no1), 15);
    chk("t5_cnt_sat", 32'(st[1]), 1);
    chk("t5_qed_ready", 32'(rdy[1]), 0);
    step();
    idle_inputs();
    step();
    chk("t5_num_orig_hold", 32'(no1), 15);
    // async reset mid-run with fail set
    #3;
    do_reset();
    chk("t6_fail", 32'(fl[0]), 0);
    chk("t6_qed_ena", 32'(ena[0]), 0);
    chk("t6_num_orig", 32'(no0), 0);
    warm_check();
    // randomized traffic against the reference model
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int c = 0; c < 350; c++) begin
        int n, nd, r;
        logic [63:0] v;
        idle_inputs();
        n = $urandom_range(0, 4);
        nd = n;
        if ($urandom_range(0, 7) == 0) nd = $urandom_range(0, 4);
        if (m_o[0] > m_d[0] && nd < 4) nd++;
        for (int l = 0; l < 8; l++) begin
          if (l < n) begin
            valid[l] = 1'b1; rfwen[l] = 1'b1; wdest[l*8 +: 8] = 8'($urandom_range(1, NPAIR));
          end else if (l >= 4 && l < 4 + nd) begin
            valid[l] = 1'b1; rfwen[l] = 1'b1; wdest[l*8 +: 8] = 8'($urandom_range(NPAIR + 1, 2*NPAIR));
          end else begin
            valid[l] = 1'($urandom); rfwen[l] = 1'($urandom);
            wdest[l*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                              ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(25, 31));
          end
        end
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(1, NPAIR);
          v = {$urandom, $urandom};
          arf[r*XLEN +: XLEN] = v;
          arf[(r+NPAIR)*XLEN +: XLEN] = v;
        end
        if ($urandom_range(0, 59) == 0) begin
          r = $urandom_range(1, 2*NPAIR);
          arf[r*XLEN +: XLEN] = {$urandom, $urandom};
        end
        if ($urandom_range(0, 9) == 0) arf[0 +: XLEN] = {$urandom, $urandom};
        step();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
